// File: rtl/des_round_sequencer.sv
// Iterative DES round controller: one shared Feistel round reused NUM_ROUNDS times per block,
// with round-key index requests to an external key schedule and a valid/ready result port.

module des_round_logic (
  input  logic [63:0] i_round_in,
  input  logic [47:0] i_round_key,
  output logic [63:0] o_round_out_c
);
  // S-boxes S1..S8, each 4 rows x 16 columns of 4-bit entries, row-major, S1 in the top bits
  localparam logic [2047:0] SBOX = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  localparam logic [191:0] P_TBL = {
    6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
    6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
    6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
    6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
  };

  // DES bit n (1-based, MSB first) of a W-bit vector lives at index W-n
  function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  b;
    logic [5:0]  idx;
    e = '0;
    s = '0;
    p = '0;
    // E expansion: group g takes DES bits 4g..4g+5 with wrap-around
    for (int g = 0; g < 8; g++) begin
      for (int j = 0; j < 6; j++) begin
        e[47-(g*6+j)] = r[31-((4*g+j+31)%32)];
      end
    end
    x = e ^ k;
    for (int g = 0; g < 8; g++) begin
      b   = x[47-6*g -: 6];
      idx = {b[5], b[0], b[4:1]};
      s[31-4*g -: 4] = SBOX[(511-(g*64+int'(idx)))*4 +: 4];
    end
    for (int i = 0; i < 32; i++) begin
      p[31-i] = s[32-int'(P_TBL[(31-i)*6 +: 6])];
    end
    return p;
  endfunction

  assign o_round_out_c = {i_round_in[31:0], i_round_in[63:32] ^ f_func(i_round_in[31:0], i_round_key)};
endmodule

module des_round_sequencer #(
  parameter int unsigned NUM_ROUNDS = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [63:0] i_in_block,
  input  logic        i_in_decrypt,
  output logic [3:0]  o_round_idx,
  input  logic [47:0] i_round_key,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [63:0] o_out_block,
  output logic        o_busy
);
  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [63:0] r_data;
  logic        r_mode;
  logic        r_in_ready;
  logic        r_out_valid;
  logic        r_busy;
  logic [3:0]  r_round_idx;
  logic [63:0] w_round_out;

  des_round_logic u_round_logic (
    .i_round_in    (r_data),
    .i_round_key   (i_round_key),
    .o_round_out_c (w_round_out)
  );

  // Control FSM; round_idx is registered one step ahead so it matches the round being computed
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_data      <= 64'd0;
      r_mode      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_round_idx <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid && r_in_ready) begin
            r_state     <= S_RUN;
            r_data      <= i_in_block;
            r_mode      <= i_in_decrypt;
            r_cnt       <= 4'd0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
            r_round_idx <= i_in_decrypt ? LAST_IDX : 4'd0;
          end
        end
        S_RUN: begin
          r_data <= w_round_out;
          if (r_cnt == LAST_IDX) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_round_idx <= 4'd0;
          end else begin
            r_cnt       <= 4'(r_cnt + 4'd1);
            r_round_idx <= r_mode ? 4'(LAST_IDX - r_cnt - 4'd1) : 4'(r_cnt + 4'd1);
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Final swap undoes the exchange performed by the last round
  assign o_out_block = {r_data[31:0], r_data[63:32]};
  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_round_idx = r_round_idx;
endmodule

// File: tb/tb_des_round_sequencer.sv
// Directed bench: wraps the sequencer with IP/FP and a combinational key schedule and checks
// known DES vectors, latency, round-key ordering, backpressure, mid-run reset and back-to-back flow.

module tb_des_round_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_block;
  logic        in_decrypt;
  logic [3:0]  round_idx;
  logic [47:0] round_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_block;
  logic        busy;

  logic [47:0] subkey [16];
  int n_tests = 0;
  int n_fail  = 0;

  localparam int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                                60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                                29,21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  always #5 clk = ~clk;

  assign round_key = subkey[round_idx];

  des_round_sequencer #(.NUM_ROUNDS(16)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_block   (in_block),
    .i_in_decrypt (in_decrypt),
    .o_round_idx  (round_idx),
    .i_round_key  (round_key),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_block  (out_block),
    .o_busy       (busy)
  );

  function automatic int ip_src(input int i);
    int r;
    int c;
    r = i / 8;
    c = i % 8;
    return ((r < 4) ? (58 + 2*r) : (57 + 2*(r-4))) - 8*c;
  endfunction

  function automatic logic [63:0] ip_f(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-ip_src(i)];
    return y;
  endfunction

  function automatic logic [63:0] fp_f(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[64-ip_src(i)] = x[63-i];
    return y;
  endfunction

  task automatic load_key(input logic [63:0] key);
    logic [55:0] cd;
    logic [55:0] cat;
    logic [27:0] c;
    logic [27:0] d;
    logic [47:0] k;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFTS[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cat = {c, d};
      for (int i = 0; i < 48; i++) k[47-i] = cat[56-PC2_T[i]];
      subkey[r] = k;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offers one block from IDLE, records round_idx over the RUN cycles, returns at first out_valid
  task automatic do_block(input logic [63:0] blk, input logic dec,
                          output logic [63:0] res, output int lat, output logic [63:0] seq);
    seq        = '0;
    in_valid   = 1'b1;
    in_block   = blk;
    in_decrypt = dec;
    tick;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (lat <= 16) seq[(lat-1)*4 +: 4] = round_idx;
      tick;
      lat++;
    end
    res = out_block;
  endtask

  localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
  localparam logic [63:0] KEY2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] PT2  = 64'h8787878787878787;
  localparam logic [63:0] PT3  = 64'hDEADBEEFCAFEF00D;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] res;
    logic [63:0] res2;
    logic [63:0] seq;
    logic [63:0] held;
    logic [63:0] blks [3];
    logic        decs [3];
    logic [63:0] results [3];
    int          rise [3];
    int          lat;
    int          cyc;
    int          acc;
    int          got;
    int          nrise;
    logic        prev_rdy;

    rst_n = 1'b0; in_valid = 1'b0; in_block = '0; in_decrypt = 1'b0; out_ready = 1'b1;
    load_key(KEY1);
    tick; tick;
    rst_n = 1'b1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_round_idx", 64'(round_idx), 64'd0);

    // Encrypt known vector, latency and ascending key order
    do_block(ip_f(PT1), 1'b0, res, lat, seq);
    chk("enc_latency", 64'(lat), 64'd17);
    chk("enc_ct", fp_f(res), CT1);
    chk("enc_idx_seq", seq, 64'hFEDCBA9876543210);
    chk("done_round_idx", 64'(round_idx), 64'd0);
    chk("done_busy", 64'(busy), 64'd1);
    tick;
    chk("enc_idle_in_ready", 64'(in_ready), 64'd1);
    chk("enc_idle_out_valid", 64'(out_valid), 64'd0);
    chk("enc_idle_busy", 64'(busy), 64'd0);

    // Decrypt with reversed key order
    do_block(ip_f(CT1), 1'b1, res, lat, seq);
    chk("dec_latency", 64'(lat), 64'd17);
    chk("dec_pt", fp_f(res), PT1);
    chk("dec_idx_seq", seq, 64'h0123456789ABCDEF);
    tick;

    // Backpressure in DONE: output held, new offers ignored
    out_ready = 1'b0;
    do_block(ip_f(PT1), 1'b0, res, lat, seq);
    chk("bp_latency", 64'(lat), 64'd17);
    held = out_block;
    chk("bp_ct", fp_f(held), CT1);
    for (int k = 0; k < 10; k++) begin
      in_valid = (k % 2 == 0);
      in_block = 64'hFFFF_0000_FFFF_0000;
      chk("bp_out_block_stable", out_block, held);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_out_valid_high", 64'(out_valid), 64'd1);
      tick;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_release_valid", 64'(out_valid), 64'd1);
    tick;
    chk("bp_idle_in_ready", 64'(in_ready), 64'd1);
    chk("bp_idle_out_valid", 64'(out_valid), 64'd0);
    chk("bp_idle_busy", 64'(busy), 64'd0);

    // Reset at RUN cycle 7 abandons the block
    in_valid = 1'b1; in_block = ip_f(PT1); in_decrypt = 1'b0;
    tick;
    in_valid = 1'b0;
    repeat (7) tick;
    chk("mid_run_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_round_idx", 64'(round_idx), 64'd0);
    load_key(KEY2);
    do_block(ip_f(PT2), 1'b0, res, lat, seq);
    chk("rst_new_latency", 64'(lat), 64'd17);
    chk("rst_new_ct", fp_f(res), 64'h0);
    tick;

    // Round trip on an arbitrary block
    load_key(KEY1);
    do_block(ip_f(PT3), 1'b0, res, lat, seq);
    tick;
    do_block(res, 1'b1, res2, lat, seq);
    chk("rt_latency", 64'(lat), 64'd17);
    chk("rt_pt", fp_f(res2), PT3);
    tick;

    // Back-to-back with in_valid held high
    blks[0] = ip_f(PT1); decs[0] = 1'b0;
    blks[1] = ip_f(CT1); decs[1] = 1'b1;
    blks[2] = ip_f(PT3); decs[2] = 1'b0;
    cyc = 0; acc = 0; got = 0; nrise = 0; prev_rdy = 1'b0;
    while (got < 3 && cyc < 200) begin
      in_valid   = (acc < 3);
      in_block   = (acc < 3) ? blks[acc] : 64'd0;
      in_decrypt = (acc < 3) ? decs[acc] : 1'b0;
      if (in_ready && !prev_rdy && nrise < 3) begin
        rise[nrise] = cyc;
        nrise++;
      end
      prev_rdy = in_ready;
      if (out_valid) begin
        results[got] = out_block;
        got++;
      end
      if (in_ready && in_valid) acc++;
      tick;
      cyc++;
    end
    in_valid = 1'b0;
    chk("b2b_accepted", 64'(acc), 64'd3);
    chk("b2b_results", 64'(got), 64'd3);
    chk("b2b_rises", 64'(nrise), 64'd3);
    chk("b2b_res0", fp_f(results[0]), CT1);
    chk("b2b_res1", fp_f(results[1]), PT1);
    chk("b2b_res2", fp_f(results[2]), fp_f(res));
    chk("b2b_gap01", 64'(rise[1] - rise[0]), 64'd18);
    chk("b2b_gap12", 64'(rise[2] - rise[1]), 64'd18);
    repeat (20) tick;
    chk("b2b_no_extra_output", 64'(out_valid), 64'd0);
    chk("b2b_no_extra_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
